// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core and its bench-side models.
package idli_pkg;

  typedef logic [3:0] slice_t;

  typedef enum logic [7:0] {
    SQI_CMD_WRITE = 8'h02,
    SQI_CMD_READ  = 8'h03
  } sqi_cmd_t;

  typedef enum logic [2:0] {
    SQI_IDLE,
    SQI_CMD,
    SQI_ADDR,
    SQI_DUMMY,
    SQI_RD,
    SQI_WR,
    SQI_ERR
  } sqi_state_t;

  localparam int SQI_ADDR_NIBS = 6;

endpackage

// File: rtl/idli_sqi_mem_m.sv
// Quad-SPI SRAM model: sequential-mode READ (0x03) / WRITE (0x02) over SCK/CS/SIO,
// oversampled on the system clock, with a backdoor port for preload and inspection.
module idli_sqi_mem_m
  import idli_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int DUMMY_NIBS = 2
) (
  input  logic              i_mem_gck,
  input  logic              i_mem_rst_n,
  input  logic              i_mem_sck,
  input  logic              i_mem_cs,
  input  slice_t            i_mem_sio,
  output slice_t            o_mem_sio,
  output logic              o_mem_sio_en,
  input  logic              i_mem_bd_wr,
  input  logic [ADDR_W-1:0] i_mem_bd_addr,
  input  logic [7:0]        i_mem_bd_wdata,
  output logic [7:0]        o_mem_bd_rdata
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int CNT_MAX = (DUMMY_NIBS > SQI_ADDR_NIBS) ? DUMMY_NIBS : SQI_ADDR_NIBS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t ADDR_LAST  = cnt_t'(SQI_ADDR_NIBS - 1);
  localparam cnt_t DUMMY_LAST = cnt_t'(DUMMY_NIBS - 1);

  logic [7:0]        r_mem [DEPTH];

  sqi_state_t        r_state;
  sqi_state_t        w_state_nxt;
  cnt_t              r_cnt;
  cnt_t              w_cnt_nxt;
  logic              r_sck_q;
  slice_t            r_hi;
  logic              r_is_rd;
  logic              w_is_rd_nxt;
  logic [ADDR_W-1:0] r_addr;

  logic              w_rise;
  logic              w_fall;
  logic              w_cap_hi;
  logic              w_addr_shift;
  logic              w_addr_inc;
  logic              w_sqi_we;
  logic              w_drive;
  logic [7:0]        w_cmd;
  logic [7:0]        w_rd_byte;
  slice_t            w_rd_nib;

  assign w_rise    = i_mem_sck & ~r_sck_q;
  assign w_fall    = ~i_mem_sck & r_sck_q;
  assign w_cmd     = {r_hi, i_mem_sio};
  assign w_rd_byte = r_mem[r_addr];
  // r_cnt[0] tracks which half of the byte goes out next: 0 = high nibble.
  assign w_rd_nib  = r_cnt[0] ? w_rd_byte[3:0] : w_rd_byte[7:4];

  assign o_mem_bd_rdata = r_mem[i_mem_bd_addr];

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_is_rd_nxt  = r_is_rd;
    w_cap_hi     = 1'b0;
    w_addr_shift = 1'b0;
    w_addr_inc   = 1'b0;
    w_sqi_we     = 1'b0;
    w_drive      = 1'b0;

    if (i_mem_cs) begin
      // CS deassert wins over any SCK edge seen on the same gck.
      w_state_nxt = SQI_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        SQI_IDLE: begin
          w_state_nxt = SQI_CMD;
          w_cnt_nxt   = '0;
        end
        SQI_CMD: if (w_rise) begin
          if (r_cnt == '0) begin
            w_cap_hi  = 1'b1;
            w_cnt_nxt = cnt_t'(1);
          end else begin
            w_cnt_nxt = '0;
            if (w_cmd == SQI_CMD_READ) begin
              w_state_nxt = SQI_ADDR;
              w_is_rd_nxt = 1'b1;
            end else if (w_cmd == SQI_CMD_WRITE) begin
              w_state_nxt = SQI_ADDR;
              w_is_rd_nxt = 1'b0;
            end else begin
              w_state_nxt = SQI_ERR;
            end
          end
        end
        SQI_ADDR: if (w_rise) begin
          w_addr_shift = 1'b1;
          if (r_cnt == ADDR_LAST) begin
            w_cnt_nxt = '0;
            if (!r_is_rd)             w_state_nxt = SQI_WR;
            else if (DUMMY_NIBS == 0) w_state_nxt = SQI_RD;
            else                      w_state_nxt = SQI_DUMMY;
          end else begin
            w_cnt_nxt = r_cnt + cnt_t'(1);
          end
        end
        SQI_DUMMY: if (w_rise) begin
          if (r_cnt == DUMMY_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = SQI_RD;
          end else begin
            w_cnt_nxt = r_cnt + cnt_t'(1);
          end
        end
        SQI_RD: if (w_fall) begin
          w_drive = 1'b1;
          if (r_cnt == '0) begin
            w_cnt_nxt = cnt_t'(1);
          end else begin
            w_cnt_nxt  = '0;
            w_addr_inc = 1'b1;
          end
        end
        SQI_WR: if (w_rise) begin
          if (r_cnt == '0) begin
            w_cap_hi  = 1'b1;
            w_cnt_nxt = cnt_t'(1);
          end else begin
            w_sqi_we   = 1'b1;
            w_addr_inc = 1'b1;
            w_cnt_nxt  = '0;
          end
        end
        SQI_ERR: ;
        default: w_state_nxt = SQI_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
    if (!i_mem_rst_n) begin
      r_state      <= SQI_IDLE;
      r_cnt        <= '0;
      r_sck_q      <= 1'b0;
      r_hi         <= '0;
      r_is_rd      <= 1'b0;
      r_addr       <= '0;
      o_mem_sio    <= '0;
      o_mem_sio_en <= 1'b0;
    end else begin
      r_sck_q <= i_mem_sck;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_is_rd <= w_is_rd_nxt;
      if (w_cap_hi) r_hi <= i_mem_sio;
      // Shifting keeps only the low ADDR_W bits of the 24-bit wire address.
      if (w_addr_shift)    r_addr <= ADDR_W'({r_addr, i_mem_sio});
      else if (w_addr_inc) r_addr <= r_addr + ADDR_W'(1);
      if (i_mem_cs) begin
        o_mem_sio_en <= 1'b0;
      end else if (w_drive) begin
        o_mem_sio_en <= 1'b1;
        o_mem_sio    <= w_rd_nib;
      end
    end
  end

  // NOTE: the storage array has no reset; contents survive i_mem_rst_n by design.
  // The SQI write is issued last so it overrides a same-address backdoor write.
  always_ff @(posedge i_mem_gck) begin
    if (i_mem_bd_wr) r_mem[i_mem_bd_addr] <= i_mem_bd_wdata;
    if (w_sqi_we)    r_mem[r_addr]        <= w_cmd;
  end

endmodule

// File: doc/idli_sqi_mem_m.md
# idli_sqi_mem_m

Synthesizable SQI SRAM model that sits directly downstream of the core's low/high memory pins in the bench, one instance per memory (lo and hi). It consumes SCK/CS/SIO from the core, decodes quad-mode READ/WRITE transactions in sequential mode, and drives read data back onto SIO. The bench preloads and inspects contents through a backdoor port.

## Interface
Parameters:
- `ADDR_W`, default 17: byte-address width; depth is 2^ADDR_W bytes.
- `DUMMY_NIBS`, default 2: dummy SCK cycles between the last address nibble and the first read nibble.

Ports:
- `i_mem_gck`  in  1  system clock; all logic on posedge.
- `i_mem_rst_n`  in  1  asynchronous, active-low reset.
- `i_mem_sck`  in  1  serial clock from the core; always low or high for ≥1 gck.
- `i_mem_cs`  in  1  chip select, active low.
- `i_mem_sio`  in  slice_t (4)  nibble from the core.
- `o_mem_sio`  out  slice_t (4)  nibble to the core.
- `o_mem_sio_en`  out  1  model is driving `o_mem_sio`.
- `i_mem_bd_wr`  in  1  backdoor write strobe.
- `i_mem_bd_addr`  in  ADDR_W  backdoor byte address (write and read).
- `i_mem_bd_wdata`  in  8  backdoor write data.
- `o_mem_bd_rdata`  out  8  combinational backdoor read of `i_mem_bd_addr`.

## Operation
- SCK edge detect: `sck_q` flop; rise = `i_mem_sck && !sck_q`, fall = `!i_mem_sck && sck_q`. Inputs sampled on the gck edge where rise is seen; outputs update on the gck edge where fall is seen.
- All nibbles MSB first; bytes are high nibble then low nibble.
- States:
  - IDLE: CS high.
  - CMD: 2 nibbles form an 8-bit command.
  - ADDR: 6 nibbles form a 24-bit address; bits above ADDR_W are ignored.
  - DUMMY: DUMMY_NIBS rises, read only.
  - RD: stream read data.
  - WR: accept write data.
  - ERR: absorbs everything.
- Transitions:
  - CS falling while IDLE → CMD.
  - After 2nd CMD nibble: 0x03 → ADDR(read), 0x02 → ADDR(write), anything else → ERR.
  - After 6th ADDR nibble: read → DUMMY (or RD if DUMMY_NIBS=0), write → WR.
  - After last dummy rise → RD.
- CS high at any time, in any state → IDLE next gck; nibble counter cleared; `o_mem_sio_en` cleared the same edge.
- WR: 2nd nibble of each byte commits `{hi,lo}` to `mem[addr]`, then addr+1. A half-received byte is discarded on CS high.
- RD: `o_mem_sio_en` sets on the first fall after entry to RD. On each fall, `o_mem_sio` outputs the next nibble of `mem[addr]`. After the low nibble is output, addr+1.
- Address arithmetic is modulo 2^ADDR_W: 2^ADDR_W−1 wraps to 0, in both read and write.
- ERR: `o_mem_sio_en` stays 0 and memory is unchanged until CS high.
- Backdoor write applies on posedge. If it hits the same address as an SQI write commit in the same cycle, the SQI write wins.
- Memory array is not reset.

## Timing
- Reset values: `o_mem_sio`=0, `o_mem_sio_en`=0, state IDLE, `sck_q`=0, address 0, nibble counter 0.
- Read turnaround: first data nibble is valid from the fall following the last dummy rise. The core samples it on the next rise.
- Write-to-read: a byte committed by SQI is visible on `o_mem_bd_rdata` the following gck.
- CS and SCK changing on the same gck: the CS deassert takes priority and the SCK edge is ignored.
- Reset mid-transaction: immediate return to IDLE, outputs to reset values, committed bytes retained.

## Structure
- `idli_pkg` additions:
  - `sqi_cmd_t` enum: `SQI_CMD_WRITE`=8'h02, `SQI_CMD_READ`=8'h03.
  - `sqi_state_t` enum: IDLE/CMD/ADDR/DUMMY/RD/WR/ERR.
  - `SQI_ADDR_NIBS`=6.
- Single module, no sub-module.
- Storage is an unpacked byte array inside the module.
- Instantiated twice beside `idli_tb_m`, wired to `o_tb_mem_{lo,hi}_*` and `i_tb_mem_{lo,hi}_sio`.

## Test plan
- Write then read: SQI write 0x02, addr 0x000010, data 0xA5 0x3C. Then read 0x03 from addr 0x000010 with 2 dummy nibbles → nibbles A,5,3,C; backdoor 0x10=0xA5, 0x11=0x3C.
- Wrap: backdoor 0x1FFFF=0x12 and 0x00000=0x34, then SQI read from 0x1FFFF for 2 bytes → 1,2,3,4. Write across the boundary also wraps.
- CS abort: write cmd, address 0x20, one data nibble 0xF, CS high → 0x20 unchanged. Next transaction decodes normally.
- Bad command 0x05 followed by 12 nibbles → `o_mem_sio_en` never 1, memory unchanged. After CS high, a subsequent read works.
- Reset mid-read: assert `i_mem_rst_n` low during RD → `o_mem_sio_en`=0 immediately and state IDLE. Previously written data is still readable after reset.
- Simultaneous backdoor and SQI write to the same address in the same cycle → SQI value stored.
